// File: rtl/mdl_pipe_bfu_lanes_pkg.sv
// pkg_bfu: shared definitions for the multi-lane butterfly pipeline.
//   - mode constants (CT / GS / PWM / bypass)
//   - block FSM state encoding
//   - default modulus, pipeline depth, (q+1)/2 helper
package pkg_bfu;

  typedef enum logic [1:0] {
    BFU_CT  = 2'b00,
    BFU_GS  = 2'b01,
    BFU_PWM = 2'b10,
    BFU_BYP = 2'b11
  } bfu_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } bfu_state_e;

  localparam int unsigned BFU_Q_DEF = 32'd536903681;
  localparam int unsigned BFU_LAT   = 5;

  // Multiplicative inverse of 2 modulo an odd q.
  function automatic int unsigned bfu_half_q(input int unsigned q);
    return (q + 1) / 2;
  endfunction

endpackage

// File: rtl/mdl_modmul_q.sv
// mdl_modmul_q: 3-stage pipelined D x D multiply modulo PARAM_Q.
// Ports:
//   iSYS_CLK, iSYS_RST : clock, asynchronous active-low reset
//   i_en               : stage advance enable (all stages freeze when low)
//   i_x, i_y           : operands
//   o_z                : (i_x * i_y) mod PARAM_Q, three enabled cycles later
module mdl_modmul_q
  import pkg_bfu::*;
#(
  parameter int unsigned D       = 30,
  parameter int unsigned PARAM_Q = BFU_Q_DEF
) (
  input  logic         iSYS_CLK,
  input  logic         iSYS_RST,
  input  logic         i_en,
  input  logic [D-1:0] i_x,
  input  logic [D-1:0] i_y,
  output logic [D-1:0] o_z
);

  localparam logic [2*D-1:0] QW = (2*D)'(PARAM_Q);

  logic [2*D-1:0] w_prod;
  logic [2*D-1:0] r_prod;
  logic [D-1:0]   r_red;
  logic [D-1:0]   r_z;

  assign w_prod = {{D{1'b0}}, i_x} * {{D{1'b0}}, i_y};

  // Stage 1 multiplies, stage 2 reduces, stage 3 is a retiming register
  // giving the reduction logic room to be balanced by synthesis.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      r_prod <= '0;
      r_red  <= '0;
      r_z    <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
      r_red  <= D'(r_prod % QW);
      r_z    <= r_red;
    end
  end

  assign o_z = r_z;

endmodule

// File: rtl/mdl_pipe_bfu_lanes.sv
// mdl_pipe_bfu_lanes: LANES parallel CT / GS / PWM butterflies mod PARAM_Q in a
// stallable 5-stage pipeline, with a block FSM counting N_BEATS input beats.
// Ports:
//   iSYS_CLK, iSYS_RST     : clock, asynchronous active-low reset
//   iFSM_START, iMODE      : start a block in IDLE, latching the mode
//   iVALID/oREADY, iA/iB/iW: input beat handshake and packed lane operands
//   oVALID/iREADY, oA/oB   : output beat handshake and packed lane results
//   oBUSY, oDONE, oERR     : FSM not idle, end-of-block pulse, sticky range error
// Optional feature: define DFN_BFU_RANGE_CHK_EN to build operand range checks
// driving oERR; otherwise oERR is tied low.
module mdl_pipe_bfu_lanes
  import pkg_bfu::*;
#(
  parameter int unsigned D       = 30,
  parameter int unsigned PARAM_Q = BFU_Q_DEF,
  parameter int unsigned LANES   = 2,
  parameter int unsigned N_BEATS = 128
) (
  input  logic               iSYS_CLK,
  input  logic               iSYS_RST,
  input  logic               iFSM_START,
  input  logic [1:0]         iMODE,
  input  logic               iVALID,
  output logic               oREADY,
  input  logic [LANES*D-1:0] iA,
  input  logic [LANES*D-1:0] iB,
  input  logic [LANES*D-1:0] iW,
  output logic               oVALID,
  input  logic               iREADY,
  output logic [LANES*D-1:0] oA,
  output logic [LANES*D-1:0] oB,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oERR
);

  localparam int unsigned  CW = $clog2(N_BEATS + 1);
  localparam logic [D-1:0] QD = D'(PARAM_Q);
  localparam logic [D:0]   Q1 = {1'b0, QD};
  localparam logic [D-1:0] HQ = D'(bfu_half_q(PARAM_Q));

  function automatic logic [D-1:0] f_half(input logic [D-1:0] x);
    return x[0] ? ((x >> 1) + HQ) : (x >> 1);
  endfunction

  bfu_state_e         r_state;
  bfu_mode_e          r_mode;
  logic [CW-1:0]      r_cnt;
  logic [BFU_LAT-1:0] r_vld;
  bfu_mode_e          r_msr [BFU_LAT-1];
  logic               w_en;
  logic               w_acc;
  logic               w_start;

  assign oVALID  = r_vld[BFU_LAT-1];
  assign w_en    = !oVALID || iREADY;
  assign oREADY  = (r_state == StRun) && w_en;
  assign w_acc   = iVALID && oREADY;
  assign w_start = (r_state == StIdle) && iFSM_START;

  // Block FSM; oBUSY and oDONE are registered alongside the state.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      r_state <= StIdle;
      r_mode  <= BFU_CT;
      r_cnt   <= '0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_mode  <= bfu_mode_e'(iMODE);
            r_cnt   <= '0;
            r_state <= StRun;
            oBUSY   <= 1'b1;
          end
        end
        StRun: begin
          if (w_acc) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N_BEATS - 1)) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (r_vld == '0) begin
            r_state <= StDone;
            oDONE   <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          oDONE   <= 1'b0;
          oBUSY   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Valid bits and per-beat mode shared by all lanes.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      r_vld <= '0;
      for (int i = 0; i < BFU_LAT - 1; i++) r_msr[i] <= BFU_CT;
    end else if (w_en) begin
      r_vld    <= {r_vld[BFU_LAT-2:0], w_acc};
      r_msr[0] <= r_mode;
      for (int i = 1; i < BFU_LAT - 1; i++) r_msr[i] <= r_msr[i-1];
    end
  end

`ifdef DFN_BFU_RANGE_CHK_EN
  logic [LANES-1:0] w_oor;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [D-1:0] w_a, w_b, w_w, w_t;
    logic [D:0]   w_sum, w_dif, w_cs, w_cd;
    logic [D-1:0] w_sum_r, w_dif_r, w_cs_r, w_cd_r, w_oa, w_ob;
    logic [D-1:0] r_x, r_y, r_oa, r_ob;
    // r_ca carries a (CT/bypass) or the reduced sum (GS); r_cb carries b for bypass.
    logic [D-1:0] r_ca [BFU_LAT-1];
    logic [D-1:0] r_cb [BFU_LAT-1];

    assign w_a = iA[l*D +: D];
    assign w_b = iB[l*D +: D];
    assign w_w = iW[l*D +: D];

`ifdef DFN_BFU_RANGE_CHK_EN
    assign w_oor[l] = (w_a >= QD) || (w_b >= QD) || (w_w >= QD);
`endif

    // S1: GS pre-add/sub
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_sum_r = (w_sum >= Q1) ? (w_sum[D-1:0] - QD) : w_sum[D-1:0];
    assign w_dif   = {1'b0, w_a} + Q1 - {1'b0, w_b};
    assign w_dif_r = (w_dif >= Q1) ? (w_dif[D-1:0] - QD) : w_dif[D-1:0];

    mdl_modmul_q #(
      .D      (D),
      .PARAM_Q(PARAM_Q)
    ) u_modmul (
      .iSYS_CLK(iSYS_CLK),
      .iSYS_RST(iSYS_RST),
      .i_en    (w_en),
      .i_x     (r_x),
      .i_y     (r_y),
      .o_z     (w_t)
    );

    // S5: CT post add/sub, GS halving
    assign w_cs   = {1'b0, r_ca[BFU_LAT-2]} + {1'b0, w_t};
    assign w_cs_r = (w_cs >= Q1) ? (w_cs[D-1:0] - QD) : w_cs[D-1:0];
    assign w_cd   = {1'b0, r_ca[BFU_LAT-2]} + Q1 - {1'b0, w_t};
    assign w_cd_r = (w_cd >= Q1) ? (w_cd[D-1:0] - QD) : w_cd[D-1:0];

    always_comb begin
      w_oa = r_ca[BFU_LAT-2];
      w_ob = r_cb[BFU_LAT-2];
      unique case (r_msr[BFU_LAT-2])
        BFU_CT: begin
          w_oa = w_cs_r;
          w_ob = w_cd_r;
        end
        BFU_GS: begin
          w_oa = f_half(r_ca[BFU_LAT-2]);
          w_ob = f_half(w_t);
        end
        BFU_PWM: begin
          w_oa = w_t;
          w_ob = '0;
        end
        default: ;
      endcase
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
        r_x  <= '0;
        r_y  <= '0;
        r_oa <= '0;
        r_ob <= '0;
        for (int i = 0; i < BFU_LAT - 1; i++) begin
          r_ca[i] <= '0;
          r_cb[i] <= '0;
        end
      end else if (w_en) begin
        r_x     <= (r_mode == BFU_GS) ? w_dif_r : w_b;
        r_y     <= w_w;
        r_ca[0] <= (r_mode == BFU_GS) ? w_sum_r : w_a;
        r_cb[0] <= w_b;
        for (int i = 1; i < BFU_LAT - 1; i++) begin
          r_ca[i] <= r_ca[i-1];
          r_cb[i] <= r_cb[i-1];
        end
        r_oa <= w_oa;
        r_ob <= w_ob;
      end
    end

    assign oA[l*D +: D] = r_oa;
    assign oB[l*D +: D] = r_ob;
  end

`ifdef DFN_BFU_RANGE_CHK_EN
  logic r_err;

  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_acc && (|w_oor)) begin
      r_err <= 1'b1;
    end
  end

  assign oERR = r_err;
`else
  assign oERR = 1'b0;
`endif

endmodule

// File: tb/tb_mdl_pipe_bfu_lanes.sv
`timescale 1ns/1ps
module tb_mdl_pipe_bfu_lanes;
  import pkg_bfu::*;

  localparam int unsigned D     = 30;
  localparam int unsigned LANES = 2;
  localparam int unsigned NB    = 8;
  localparam longint      Q     = 64'd536903681;
  localparam int unsigned W     = LANES * D;

  typedef logic [W-1:0] vec_t;
  typedef struct {
    vec_t a;
    vec_t b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic vin = 1'b0;
  logic rdy = 1'b1;
  vec_t ia = '0, ib = '0, iw = '0;
  logic oready, ovalid, obusy, odone, oerr;
  vec_t oa, ob;

  always #5 clk = ~clk;

  mdl_pipe_bfu_lanes #(
    .D      (D),
    .PARAM_Q(32'd536903681),
    .LANES  (LANES),
    .N_BEATS(NB)
  ) dut (
    .iSYS_CLK  (clk),
    .iSYS_RST  (rst_n),
    .iFSM_START(start),
    .iMODE     (mode),
    .iVALID    (vin),
    .oREADY    (oready),
    .iA        (ia),
    .iB        (ib),
    .iW        (iw),
    .oVALID    (ovalid),
    .iREADY    (rdy),
    .oA        (oa),
    .oB        (ob),
    .oBUSY     (obusy),
    .oDONE     (odone),
    .oERR      (oerr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit pat_en = 1'b0;
  int pcnt = 0;
  logic [1:0] m_mode = 2'b00;
  exp_t expq[$];
  vec_t va[NB], vb[NB], vw[NB];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Reference arithmetic straight from the modular definitions.
  function automatic longint f_half(input longint x);
    return (x % 2 == 0) ? x / 2 : x / 2 + (Q + 1) / 2;
  endfunction

  function automatic exp_t model(input logic [1:0] m, input vec_t a, input vec_t b,
                                 input vec_t w);
    exp_t e;
    longint x, y, z, t, ra, rb;
    e.a = '0;
    e.b = '0;
    for (int l = 0; l < LANES; l++) begin
      x = longint'(a[l*D +: D]);
      y = longint'(b[l*D +: D]);
      z = longint'(w[l*D +: D]);
      case (m)
        2'd0: begin
          t  = (y * z) % Q;
          ra = (x + t) % Q;
          rb = (x - t + Q) % Q;
        end
        2'd1: begin
          ra = f_half((x + y) % Q);
          rb = f_half((((x - y + Q) % Q) * z) % Q);
        end
        2'd2: begin
          ra = (y * z) % Q;
          rb = 0;
        end
        default: begin
          ra = x;
          rb = y;
        end
      endcase
      e.a[l*D +: D] = ra[D-1:0];
      e.b[l*D +: D] = rb[D-1:0];
    end
    return e;
  endfunction

  // Scoreboard: push on accept, compare every cycle an output is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vin && oready) expq.push_back(model(m_mode, ia, ib, iw));
      if (ovalid) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got oVALID=1 want no pending beat (t=%0t)", $time);
        end else begin
          chk("out_a", oa, expq[0].a);
          chk("out_b", ob, expq[0].b);
          if (rdy) void'(expq.pop_front());
        end
      end
`ifndef DFN_BFU_RANGE_CHK_EN
      chk("err_tied", oerr, 0);
`endif
    end
  end

  always @(negedge clk) if (odone) done_cnt++;

  // iREADY: steady high, or 3 low / 2 high when pat_en.
  initial forever begin
    @(posedge clk);
    #1;
    if (pat_en) begin
      pcnt = (pcnt + 1) % 5;
      rdy  = (pcnt >= 3);
    end else begin
      rdy = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want end of test");
    $fatal(1, "watchdog");
  end

  task automatic fill_rand();
    for (int i = 0; i < NB; i++) begin
      for (int l = 0; l < LANES; l++) begin
        va[i][l*D +: D] = D'($urandom_range(0, 32'(Q - 1)));
        vb[i][l*D +: D] = D'($urandom_range(0, 32'(Q - 1)));
        vw[i][l*D +: D] = D'($urandom_range(0, 32'(Q - 1)));
      end
    end
  endtask

  task automatic set_beat0(input logic [D-1:0] a, input logic [D-1:0] b, input logic [D-1:0] w);
    va[0] = {LANES{a}};
    vb[0] = {LANES{b}};
    vw[0] = {LANES{w}};
  endtask

  task automatic run_block(input logic [1:0] md, input bit pat, input bit lit,
                           input vec_t la, input vec_t lb);
    int  nacc;
    int  guard;
    int  d0;
    bit  acc;
    @(posedge clk);
    #1;
    start  = 1'b1;
    mode   = md;
    m_mode = md;
    pat_en = pat;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~md;
    nacc  = 0;
    guard = 0;
    while (nacc < NB && guard < 500) begin
      vin = 1'b1;
      ia  = va[nacc];
      ib  = vb[nacc];
      iw  = vw[nacc];
      @(negedge clk);
      acc = oready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        nacc++;
        if (lit && nacc == 1) begin
          vin = 1'b0;
          repeat (3) @(posedge clk);
          @(negedge clk);
          chk("lat_early", ovalid, 0);
          @(posedge clk);
          @(negedge clk);
          chk("lat_valid", ovalid, 1);
          chk("lit_a", oa, la);
          chk("lit_b", ob, lb);
          @(posedge clk);
          #1;
        end
      end
    end
    vin = 1'b0;
    chk("beats_accepted", nacc, NB);
    guard = 0;
    d0    = done_cnt;
    while (odone !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("done_pulse", odone, 1);
    chk("drained", expq.size(), 0);
    chk("busy_in_done", obusy, 1);
    @(negedge clk);
    chk("done_one_cycle", odone, 0);
    chk("busy_drop", obusy, 0);
    chk("done_count", done_cnt - d0, 1);
    pat_en = 1'b0;
  endtask

  initial begin
    int  n;
    int  guard;
    bit  acc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", oready, 0);
    chk("rst_valid", ovalid, 0);
    chk("rst_a", oa, 0);
    chk("rst_b", ob, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_done", odone, 0);
    chk("rst_err", oerr, 0);
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    vin = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", oready, 0);
    @(posedge clk);
    #1;
    vin = 1'b0;

    fill_rand();
    set_beat0(30'd5, 30'd3, 30'd2);
    run_block(BFU_CT, 1'b0, 1'b1, {LANES{30'd11}}, {LANES{30'd536903680}});
    fill_rand();
    set_beat0(30'd4, 30'd1, 30'd1);
    run_block(BFU_GS, 1'b0, 1'b1, {LANES{30'd268451843}}, {LANES{30'd268451842}});
    fill_rand();
    set_beat0(30'd5, 30'd3, 30'd2);
    run_block(BFU_GS, 1'b0, 1'b1, {LANES{30'd4}}, {LANES{30'd2}});
    fill_rand();
    set_beat0(30'd123, 30'd536903680, 30'd536903680);
    run_block(BFU_PWM, 1'b0, 1'b1, {LANES{30'd1}}, {LANES{30'd0}});
    fill_rand();
    set_beat0(30'd7, 30'd9, 30'd1000);
    run_block(BFU_BYP, 1'b0, 1'b1, {LANES{30'd7}}, {LANES{30'd9}});

    fill_rand();
    run_block(BFU_GS, 1'b1, 1'b0, '0, '0);
    fill_rand();
    run_block(BFU_CT, 1'b1, 1'b0, '0, '0);

    // Reset while the 4th beat of a block is being offered.
    fill_rand();
    @(posedge clk);
    #1;
    start  = 1'b1;
    mode   = BFU_CT;
    m_mode = BFU_CT;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 0;
    guard = 0;
    while (n < 3 && guard < 100) begin
      vin = 1'b1;
      ia  = va[n];
      ib  = vb[n];
      iw  = vw[n];
      @(negedge clk);
      acc = oready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) n++;
    end
    vin = 1'b1;
    ia  = va[3];
    ib  = vb[3];
    iw  = vw[3];
    chk("pre_rst_busy", obusy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", obusy, 0);
    chk("mid_rst_ready", oready, 0);
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_a", oa, 0);
    chk("mid_rst_b", ob, 0);
    chk("mid_rst_done", odone, 0);
    expq.delete();
    vin = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_rand();
    run_block(BFU_PWM, 1'b0, 1'b0, '0, '0);

`ifdef DFN_BFU_RANGE_CHK_EN
    fill_rand();
    vb[0][D-1:0] = 30'(Q);
    run_block(BFU_CT, 1'b0, 1'b0, '0, '0);
    chk("err_set", oerr, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", oerr, 1);
    fill_rand();
    run_block(BFU_BYP, 1'b0, 1'b0, '0, '0);
    chk("err_cleared", oerr, 0);
`else
    chk("err_off", oerr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
